// File: rtl/clock_set_ctrl_pkg.sv
// clock_pkg
// Shared definitions for the time-setting controller: FSM state encoding,
// edit_field codes, field limits and small helpers for clamping captured
// values and wrapping incremented ones.
package clock_pkg;

  localparam int TIME_W = 6;

  localparam logic [TIME_W-1:0] HH_MAX = 6'd23;
  localparam logic [TIME_W-1:0] MS_MAX = 6'd59;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_HH = 3'd1,
    ST_SET_MM = 3'd2,
    ST_SET_SS = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HH   = 2'd1,
    FIELD_MM   = 2'd2,
    FIELD_SS   = 2'd3
  } field_t;

  // A live value beyond the field limit (e.g. a corrupted counter) is
  // replaced by 0 so editing always starts from a legal value.
  function automatic logic [TIME_W-1:0] clamp_field(input logic [TIME_W-1:0] v,
                                                    input logic [TIME_W-1:0] max_v);
    return (v > max_v) ? '0 : v;
  endfunction

  // Increment with wrap to 0 once the limit is reached.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    return (v >= max_v) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_rise_detect.sv
// rise_detect
// Registered rising-edge detector for a debounced, synchronous button level.
// Ports:
//   clk   - system clock, registers update on the falling edge
//   reset - asynchronous active-low reset
//   btn   - button level
//   rise  - one-cycle pulse, registered, one edge after the rise is sampled
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q, btn_d;
  logic rise_q, rise_d;

  always_comb begin
    btn_d  = btn;
    rise_d = btn & ~btn_q;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      btn_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      btn_q  <= btn_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Tick scheduler and time-setting controller for the hh:mm:ss counter.
// Divides clk into a one-cycle tick_en, freezes it while the user edits the
// time with mode/inc buttons, and issues a one-cycle load when editing ends.
// Ports:
//   clk                    - system clock, registers update on the falling edge
//   reset                  - asynchronous active-low reset
//   mode_btn, inc_btn      - debounced button levels
//   cur_hh/cur_mm/cur_ss   - live time, captured when editing starts
//   tick_en                - one-cycle advance pulse to the counter
//   load                   - one-cycle strobe, counter takes set_*
//   set_hh/set_mm/set_ss   - edited time values
//   edit_field             - 0 none, 1 hh, 2 mm, 3 ss
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic [TIME_W-1:0] cur_hh,
  input  logic [TIME_W-1:0] cur_mm,
  input  logic [TIME_W-1:0] cur_ss,
  output logic              tick_en,
  output logic              load,
  output logic [TIME_W-1:0] set_hh,
  output logic [TIME_W-1:0] set_mm,
  output logic [TIME_W-1:0] set_ss,
  output logic [1:0]        edit_field
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic mode_rise, inc_rise;

  rise_detect u_mode_rise (
    .clk   (clk),
    .reset (reset),
    .btn   (mode_btn),
    .rise  (mode_rise)
  );

  rise_detect u_inc_rise (
    .clk   (clk),
    .reset (reset),
    .btn   (inc_btn),
    .rise  (inc_rise)
  );

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                tick_q, tick_d;
  logic                load_q, load_d;
  logic [TIME_W-1:0]   set_hh_q, set_hh_d;
  logic [TIME_W-1:0]   set_mm_q, set_mm_d;
  logic [TIME_W-1:0]   set_ss_q, set_ss_d;
  field_t              edit_field_q, edit_field_d;

  // mode_rise is checked before inc_rise in every SET state so a
  // simultaneous increment is dropped.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    set_hh_d = set_hh_q;
    set_mm_d = set_mm_q;
    set_ss_d = set_ss_q;

    case (state_q)
      ST_RUN: begin
        if (mode_rise) begin
          // Leaving RUN: the prescaler holds and no tick is issued, so
          // tick_en can never appear in a SET state.
          state_d  = ST_SET_HH;
          set_hh_d = clamp_field(cur_hh, HH_MAX);
          set_mm_d = clamp_field(cur_mm, MS_MAX);
          set_ss_d = clamp_field(cur_ss, MS_MAX);
        end else if (presc_q == PRESC_LAST) begin
          tick_d  = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      ST_SET_HH: begin
        if (mode_rise)     state_d  = ST_SET_MM;
        else if (inc_rise) set_hh_d = wrap_inc(set_hh_q, HH_MAX);
      end
      ST_SET_MM: begin
        if (mode_rise)     state_d  = ST_SET_SS;
        else if (inc_rise) set_mm_d = wrap_inc(set_mm_q, MS_MAX);
      end
      ST_SET_SS: begin
        if (mode_rise)     state_d  = ST_COMMIT;
        else if (inc_rise) set_ss_d = wrap_inc(set_ss_q, MS_MAX);
      end
      ST_COMMIT: begin
        // Restart the prescaler so the first tick comes a full period later.
        state_d = ST_RUN;
        presc_d = '0;
      end
      default: begin
        state_d = ST_RUN;
        presc_d = '0;
      end
    endcase

    // load and edit_field are registered from the next state so they line
    // up with the state they describe.
    load_d = (state_d == ST_COMMIT);
    case (state_d)
      ST_SET_HH: edit_field_d = FIELD_HH;
      ST_SET_MM: edit_field_d = FIELD_MM;
      ST_SET_SS: edit_field_d = FIELD_SS;
      default:   edit_field_d = FIELD_NONE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      load_q       <= 1'b0;
      set_hh_q     <= '0;
      set_mm_q     <= '0;
      set_ss_q     <= '0;
      edit_field_q <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      load_q       <= load_d;
      set_hh_q     <= set_hh_d;
      set_mm_q     <= set_mm_d;
      set_ss_q     <= set_ss_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign tick_en    = tick_q;
  assign load       = load_q;
  assign set_hh     = set_hh_q;
  assign set_mm     = set_mm_q;
  assign set_ss     = set_ss_q;
  assign edit_field = edit_field_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV = 4. The DUT acts on the
// falling clock edge; inputs are driven and outputs sampled 1 time unit
// after each falling edge.
module tb_clock_set_ctrl;

  logic       clk;
  logic       reset;
  logic       modeBtn;
  logic       incBtn;
  logic [5:0] curHh, curMm, curSs;
  logic       tickEn;
  logic       load;
  logic [5:0] setHh, setMm, setSs;
  logic [1:0] editField;

  int assertCount = 0;
  int failCount   = 0;

  clock_set_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_btn   (modeBtn),
    .inc_btn    (incBtn),
    .cur_hh     (curHh),
    .cur_mm     (curMm),
    .cur_ss     (curSs),
    .tick_en    (tickEn),
    .load       (load),
    .set_hh     (setHh),
    .set_mm     (setMm),
    .set_ss     (setSs),
    .edit_field (editField)
  );

  // Free-running clock, falling edges at 5, 15, 25, ...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Step past n falling edges and settle just after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Hold the given buttons for holdCycles edges, release, then one more edge
  // so the registered rise has been acted on.
  task automatic applyStimulus(input logic mode, input logic inc, input int holdCycles);
    modeBtn = mode;
    incBtn  = inc;
    waitCycles(holdCycles);
    modeBtn = 1'b0;
    incBtn  = 1'b0;
    waitCycles(1);
  endtask

  task automatic checkSet(input string tag, input logic [5:0] hh,
                          input logic [5:0] mm, input logic [5:0] ss);
    checkOutput({tag, "_hh"}, setHh, hh);
    checkOutput({tag, "_mm"}, setMm, mm);
    checkOutput({tag, "_ss"}, setSs, ss);
  endtask

  initial begin
    reset   = 1'b0;
    modeBtn = 1'b0;
    incBtn  = 1'b0;
    curHh   = 6'd10;
    curMm   = 6'd20;
    curSs   = 6'd30;

    // Reset state
    waitCycles(2);
    checkOutput("reset_tick", tickEn, 0);
    checkOutput("reset_load", load, 0);
    checkOutput("reset_field", editField, 0);
    checkSet("reset_set", 6'd0, 6'd0, 6'd0);
    reset = 1'b1;

    // Tick period: pulse after every 4th edge, no load
    for (int i = 1; i <= 20; i++) begin
      waitCycles(1);
      checkOutput($sformatf("tick_period_%0d", i), tickEn, (i % 4 == 0) ? 1 : 0);
      checkOutput($sformatf("run_load_%0d", i), load, 0);
    end

    // Full edit from 10:20:30
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("enter_field", editField, 1);
    checkSet("capture", 6'd10, 6'd20, 6'd30);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkSet("inc_hh", 6'd12, 6'd20, 6'd30);

    // Tick frozen while editing
    for (int i = 1; i <= 10; i++) begin
      waitCycles(1);
      checkOutput($sformatf("freeze_tick_%0d", i), tickEn, 0);
    end

    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("field_mm", editField, 2);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("field_ss", editField, 3);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("commit_load", load, 1);
    checkOutput("commit_field", editField, 0);
    checkOutput("commit_tick", tickEn, 0);
    checkSet("commit_set", 6'd12, 6'd20, 6'd30);

    // RUN re-entry, then first tick 4 edges later
    waitCycles(1);
    checkOutput("reentry_load", load, 0);
    checkOutput("reentry_tick", tickEn, 0);
    for (int i = 1; i <= 4; i++) begin
      waitCycles(1);
      checkOutput($sformatf("restart_tick_%0d", i), tickEn, (i == 4) ? 1 : 0);
      checkOutput($sformatf("restart_load_%0d", i), load, 0);
    end

    // inc rise in RUN is ignored and set_* holds
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("run_inc_field", editField, 0);
    checkSet("run_inc", 6'd12, 6'd20, 6'd30);

    // Wrap and clamp from 23:59:62
    curHh = 6'd23;
    curMm = 6'd59;
    curSs = 6'd62;
    applyStimulus(1'b1, 1'b0, 1);
    checkSet("clamp", 6'd23, 6'd59, 6'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkSet("wrap_hh", 6'd0, 6'd59, 6'd0);

    // Held mode button advances exactly once
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("held_mode_field", editField, 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkSet("wrap_mm", 6'd0, 6'd0, 6'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkSet("inc_mm", 6'd0, 6'd1, 6'd0);

    // Simultaneous rises: mode wins, mm unchanged
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("simul_field", editField, 3);
    checkSet("simul", 6'd0, 6'd1, 6'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkSet("inc_ss", 6'd0, 6'd1, 6'd1);

    // Reset mid-edit in SET_SS
    reset = 1'b0;
    #1;
    checkOutput("midreset_field", editField, 0);
    checkOutput("midreset_load", load, 0);
    checkOutput("midreset_tick", tickEn, 0);
    checkSet("midreset", 6'd0, 6'd0, 6'd0);
    waitCycles(1);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      waitCycles(1);
      checkOutput($sformatf("postreset_load_%0d", i), load, 0);
      checkOutput($sformatf("postreset_field_%0d", i), editField, 0);
      checkOutput($sformatf("postreset_tick_%0d", i), tickEn, (i == 4) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
